prog_sequencer: RTL and testbench

Hardware launcher that runs up to three CPU programs (1/x divide, 16/8 divide, square root) back-to-back without bench intervention. Sits between a host/bench and the CPU core: drives the CPU's reset and start pins with the required pulse shapes, selects the active program, waits for the CPU's Ack, times each run, and reports completion or a watchdog timeout.

---
 rtl/prog_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_prog_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Launches up to three CPU programs back-to-back, shaping the CPU reset/start pulses and timing each run.
// Optional watchdog abort compiled in with `define PROG_SEQ_TIMEOUT_EN.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | after reset; CPU held in reset, waiting for go
//  PICK   | select lowest pending program, or finish if none left
//  LAUNCH | CPU start high (with reset) for START_CYCLES
//  HOLD   | CPU start low, reset still high, for HOLD_CYCLES
//  RUN    | CPU released; count cycles until ack (or watchdog)
//  FIN    | sequence complete; done/err held until next go
module prog_sequencer #(
    parameter int              START_CYCLES = 2,
    parameter int              HOLD_CYCLES  = 2,
    parameter int              CW           = 16,
    parameter logic [CW-1:0]   TIMEOUT      = 16'hFFFF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          go_i,
    input  logic [2:0]    prog_mask_i,
    input  logic          cpu_ack_i,
    output logic          cpu_reset_o,
    output logic          cpu_start_o,
    output logic [1:0]    prog_sel_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [1:0]    err_prog_o,
    output logic [CW-1:0] last_cycles_o,
    output logic [2:0]    done_mask_o
);

    localparam int PW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_LAUNCH,
        S_HOLD,
        S_RUN,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    pending_q, pending_d;
    logic [1:0]    prog_sel_q, prog_sel_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] last_cycles_q, last_cycles_d;
    logic [2:0]    done_mask_q, done_mask_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          cpu_start_q, cpu_start_d;
`ifdef PROG_SEQ_TIMEOUT_EN
    logic          err_q, err_d;
    logic [1:0]    err_prog_q, err_prog_d;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            prog_sel_q    <= '0;
            phase_q       <= '0;
            count_q       <= '0;
            last_cycles_q <= '0;
            done_mask_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cpu_reset_q   <= 1'b1;
            cpu_start_q   <= 1'b0;
`ifdef PROG_SEQ_TIMEOUT_EN
            err_q         <= 1'b0;
            err_prog_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            prog_sel_q    <= prog_sel_d;
            phase_q       <= phase_d;
            count_q       <= count_d;
            last_cycles_q <= last_cycles_d;
            done_mask_q   <= done_mask_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cpu_reset_q   <= cpu_reset_d;
            cpu_start_q   <= cpu_start_d;
`ifdef PROG_SEQ_TIMEOUT_EN
            err_q         <= err_d;
            err_prog_q    <= err_prog_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        prog_sel_d    = prog_sel_q;
        phase_d       = phase_q;
        count_d       = count_q;
        last_cycles_d = last_cycles_q;
        done_mask_d   = done_mask_q;
        busy_d        = busy_q;
        done_d        = done_q;
`ifdef PROG_SEQ_TIMEOUT_EN
        err_d         = err_q;
        err_prog_d    = err_prog_q;
`endif

        case (state_q)
            S_IDLE, S_FIN: begin
                if (go_i) begin
                    pending_d   = prog_mask_i;
                    done_d      = 1'b0;
                    done_mask_d = '0;
                    busy_d      = 1'b1;
`ifdef PROG_SEQ_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = S_PICK;
                end
            end
            S_PICK: begin
                if (pending_q == 3'b000) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end else begin
                    if (pending_q[0])      prog_sel_d = 2'd0;
                    else if (pending_q[1]) prog_sel_d = 2'd1;
                    else                   prog_sel_d = 2'd2;
                    // x & (x-1) drops the lowest set bit, i.e. the program just picked
                    pending_d = pending_q & (pending_q - 3'd1);
                    phase_d   = PW'(START_CYCLES - 1);
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (phase_q == '0) begin
                    phase_d = PW'(HOLD_CYCLES - 1);
                    state_d = S_HOLD;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            S_HOLD: begin
                if (phase_q == '0) begin
                    count_d = '0;
                    state_d = S_RUN;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            S_RUN: begin
                if (cpu_ack_i) begin
                    last_cycles_d           = count_q;
                    done_mask_d[prog_sel_q] = 1'b1;
                    state_d                 = S_PICK;
`ifdef PROG_SEQ_TIMEOUT_EN
                end else if (count_q == TIMEOUT) begin
                    err_d      = 1'b1;
                    err_prog_d = prog_sel_q;
                    pending_d  = '0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_FIN;
`endif
                end else if (count_q != '1) begin
                    count_d = count_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // CPU pins are registered from the next state so they change cleanly with the FSM
        cpu_reset_d = (state_d != S_RUN);
        cpu_start_d = (state_d == S_LAUNCH);
    end

    assign cpu_reset_o   = cpu_reset_q;
    assign cpu_start_o   = cpu_start_q;
    assign prog_sel_o    = prog_sel_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign last_cycles_o = last_cycles_q;
    assign done_mask_o   = done_mask_q;

`ifdef PROG_SEQ_TIMEOUT_EN
    assign err_o      = err_q;
    assign err_prog_o = err_prog_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err_o          = 1'b0;
    assign err_prog_o     = 2'd0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: a small CPU model acks a programmable number of cycles after reset release.
// Build with `define PROG_SEQ_TIMEOUT_EN to exercise the watchdog instead of counter saturation.
module tb_prog_sequencer;

`ifdef PROG_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO = 16'd100;
`else
    localparam logic [15:0] TO = 16'hFFFF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [2:0]  mask = 3'b000;
    logic        cpu_ack = 1'b0;
    logic        cpu_reset, cpu_start, busy, done, err;
    logic [1:0]  prog_sel, err_prog;
    logic [15:0] last_cycles;
    logic [2:0]  done_mask;

    prog_sequencer #(
        .START_CYCLES(2),
        .HOLD_CYCLES (2),
        .CW          (16),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .go_i         (go),
        .prog_mask_i  (mask),
        .cpu_ack_i    (cpu_ack),
        .cpu_reset_o  (cpu_reset),
        .cpu_start_o  (cpu_start),
        .prog_sel_o   (prog_sel),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .err_prog_o   (err_prog),
        .last_cycles_o(last_cycles),
        .done_mask_o  (done_mask)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ack_delay = 40;
    int   never_prog = 3;
    bit   ack_lh = 1'b0;
    int   cpu_cnt = 0;
    int   run_len = 0;
    logic prev_rst = 1'b1;
    int   len_q[$];
    int   sel_q[$];
    int   lc_q[$];

    // CPU model plus pulse/result monitor, evaluated on the falling edge
    always @(negedge clk) begin
        if (cpu_reset) begin
            cpu_cnt = 0;
            cpu_ack = ack_lh;
        end else begin
            cpu_ack = (cpu_cnt >= ack_delay) && (int'(prog_sel) != never_prog);
            cpu_cnt++;
        end
        if (cpu_start) begin
            if (run_len == 0) sel_q.push_back(int'(prog_sel));
            run_len++;
        end else if (run_len != 0) begin
            len_q.push_back(run_len);
            run_len = 0;
        end
        if (cpu_reset && !prev_rst) lc_q.push_back(int'(last_cycles));
        prev_rst = cpu_reset;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        len_q.delete();
        sel_q.delete();
        lc_q.delete();
        run_len = 0;
    endtask

    // leaves the caller at the falling edge just after the accepting edge
    task automatic start_seq(input logic [2:0] m);
        @(negedge clk);
        mask = m;
        go   = 1'b1;
        @(negedge clk);
        go   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_cpu_start", 32'(cpu_start), 32'd0);
        chk("rst_prog_sel", 32'(prog_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_prog", 32'(err_prog), 32'd0);
        chk("rst_last", 32'(last_cycles), 32'd0);
        chk("rst_done_mask", 32'(done_mask), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // programs 0 and 2, each acking 40 cycles after reset release
        clear_mon();
        ack_delay = 40;
        start_seq(3'b101);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_start_pick", 32'(cpu_start), 32'd0);
        @(negedge clk);
        chk("t1_start_a", 32'(cpu_start), 32'd1);
        chk("t1_sel0", 32'(prog_sel), 32'd0);
        @(negedge clk);
        chk("t1_start_b", 32'(cpu_start), 32'd1);
        @(negedge clk);
        chk("t1_start_off", 32'(cpu_start), 32'd0);
        chk("t1_hold_a", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk("t1_hold_b", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk("t1_run", 32'(cpu_reset), 32'd0);
        wait_done("t1", 500);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_done_mask", 32'(done_mask), 32'd5);
        chk("t1_npulse", 32'(len_q.size()), 32'd2);
        chk("t1_nlast", 32'(lc_q.size()), 32'd2);
        for (int i = 0; i < len_q.size() && i < 2; i++) begin
            chk("t1_plen", 32'(len_q[i]), 32'd2);
            chk("t1_psel", 32'(sel_q[i]), (i == 0) ? 32'd0 : 32'd2);
        end
        for (int i = 0; i < lc_q.size() && i < 2; i++)
            chk("t1_last", 32'(lc_q[i]), 32'd40);

        // empty mask completes in two edges without launching
        clear_mon();
        start_seq(3'b000);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy_end", 32'(busy), 32'd0);
        chk("t2_done_mask", 32'(done_mask), 32'd0);
        repeat (3) @(negedge clk);
        chk("t2_npulse", 32'(len_q.size()), 32'd0);
        chk("t2_reset", 32'(cpu_reset), 32'd1);

        // extra go while busy and ack during launch/hold are both ignored
        clear_mon();
        ack_delay = 10;
        ack_lh = 1'b1;
        start_seq(3'b010);
        @(negedge clk);
        go = 1'b1;
        repeat (6) @(negedge clk);
        go = 1'b0;
        ack_lh = 1'b0;
        wait_done("t3", 500);
        @(negedge clk);
        chk("t3_busy_end", 32'(busy), 32'd0);
        chk("t3_last", 32'(last_cycles), 32'd10);
        chk("t3_done_mask", 32'(done_mask), 32'd2);
        chk("t3_npulse", 32'(len_q.size()), 32'd1);
        if (len_q.size() != 0) begin
            chk("t3_plen", 32'(len_q[0]), 32'd2);
            chk("t3_psel", 32'(sel_q[0]), 32'd1);
        end

        // reset during launch, then a fresh sequence starts from scratch
        start_seq(3'b110);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t4_cpu_start", 32'(cpu_start), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_done_mask", 32'(done_mask), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
        ack_delay = 5;
        start_seq(3'b001);
        @(negedge clk);
        chk("t4_sel", 32'(prog_sel), 32'd0);
        chk("t4_start", 32'(cpu_start), 32'd1);
        wait_done("t4", 500);
        chk("t4_done_mask2", 32'(done_mask), 32'd1);
        chk("t4_npulse", 32'(len_q.size()), 32'd1);
        chk("t4_last", 32'(last_cycles), 32'd5);

`ifdef PROG_SEQ_TIMEOUT_EN
        // program 1 never acks: watchdog aborts before program 2
        clear_mon();
        ack_delay = 5;
        never_prog = 1;
        start_seq(3'b111);
        wait_done("t5", 1000);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_err_prog", 32'(err_prog), 32'd1);
        chk("t5_done_mask", 32'(done_mask), 32'd1);
        chk("t5_npulse", 32'(len_q.size()), 32'd2);
        chk("t5_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_last", 32'(last_cycles), 32'd5);
        never_prog = 3;
`else
        // ack far beyond the counter range: count saturates
        clear_mon();
        ack_delay = 70000;
        start_seq(3'b001);
        wait_done("t5", 71000);
        chk("t5_last_sat", 32'(last_cycles), 32'h0000FFFF);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_done_mask", 32'(done_mask), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
